axi_4_lite_regbank: RTL
=======================

Name: axi_4_lite_regbank

Overview:
- Parametrised AXI4-Lite slave register bank. Generalises the fixed-size slave to configurable data width, address width and register count.
- Adds byte-strobe writes, independent AW/W acceptance, and SLVERR responses for out-of-range addresses and read-only registers.
- Exposes a per-register write pulse and hardware-fed read-only registers to user logic.
- Sits between the PS/interconnect AXI master port and the PL user logic.

Parameters:
- DATA_WIDTH, 32, AXI data width in bits; 32 or 64 only.
- ADDR_WIDTH, 8, AXI address width in bits.
- NUM_REGS, 8, number of registers; 2..2^(ADDR_WIDTH-ADDR_LSB).
- RO_MASK, {NUM_REGS{1'b0}}, bit i=1 makes register i read-only; its value comes from hw_ro_in.
- ADDR_LSB derived = log2(DATA_WIDTH/8); index = ADDR[ADDR_WIDTH-1:ADDR_LSB]; low address bits ignored.

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESETN  in  1  synchronous active-low reset
- S_AXI_AWVALID/AWREADY  in/out  1  write address handshake
- S_AXI_AWADDR  in  ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_WVALID/WREADY  in/out  1  write data handshake
- S_AXI_WDATA  in  DATA_WIDTH  write data
- S_AXI_WSTRB  in  DATA_WIDTH/8  byte enables
- S_AXI_BVALID/BREADY  out/in  1  write response handshake
- S_AXI_BRESP  out  2  OKAY=2'b00, SLVERR=2'b10
- S_AXI_ARVALID/ARREADY  in/out  1  read address handshake
- S_AXI_ARADDR  in  ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_RVALID/RREADY  out/in  1  read data handshake
- S_AXI_RDATA  out  DATA_WIDTH  read data
- S_AXI_RRESP  out  2  read response
- regs_out  out  NUM_REGS*DATA_WIDTH  flattened RW register contents; reg i at [i*DATA_WIDTH +: DATA_WIDTH]
- hw_ro_in  in  NUM_REGS*DATA_WIDTH  values returned for RO registers; slices of RW registers unused
- wr_pulse  out  NUM_REGS  one-cycle strobe on the cycle register i is updated

Behaviour:
- Reset (ARESETN=0 at a clock edge):
  - All registers = 0.
  - All READY/VALID outputs = 0; BRESP, RRESP, RDATA = 0; wr_pulse = 0.
  - Both FSMs go to IDLE. Reset mid-transaction abandons the transaction with no response.
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_COMMIT, W_RESP.
  - W_IDLE: AWREADY=WREADY=1.
    - AW and W handshake in the same cycle -> W_COMMIT.
    - AW only -> latch address, -> W_HAVE_ADDR (AWREADY=0, WREADY=1).
    - W only -> latch data and strobe, -> W_HAVE_DATA (WREADY=0, AWREADY=1).
  - W_HAVE_ADDR / W_HAVE_DATA: wait for the missing handshake -> W_COMMIT.
  - W_COMMIT (1 cycle, both readies 0):
    - index >= NUM_REGS or RO_MASK[index]: no update, BRESP=SLVERR.
    - Otherwise update only bytes with WSTRB=1, pulse wr_pulse[index], BRESP=OKAY. WSTRB=0 still yields OKAY and a pulse.
    - -> W_RESP with BVALID=1.
  - W_RESP: BVALID and BRESP held until BREADY=1; then BVALID=0 -> W_IDLE. A new AW/W is accepted the cycle after.
  - Readies are registered; AW+W -> BVALID latency is 2 cycles minimum.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. On ARVALID, capture RDATA/RRESP in the same edge and -> R_DATA, ARREADY=0, RVALID=1 (1-cycle latency).
  - Read data source: RW register -> stored value; RO register -> hw_ro_in slice sampled at the handshake edge.
  - Out-of-range read -> RDATA=0, RRESP=SLVERR.
  - R_DATA: RDATA/RRESP stable while RVALID=1 and RREADY=0; on RREADY -> R_IDLE.
- Read and write channels are fully independent.
  - Read handshake in the same cycle as W_COMMIT to the same register returns the old value.
  - Read handshake one cycle after W_COMMIT returns the new value.
- regs_out is driven from registers, with no combinational path from AXI inputs. RO slots of regs_out = 0.

Test Plan:
- Reset then write 0xDEADBEEF to addr 0x04, WSTRB=4'hF, AW+W together -> BVALID 2 cycles later with BRESP=00; wr_pulse[1] pulses once; regs_out reg1=0xDEADBEEF; read 0x04 -> RDATA=0xDEADBEEF, RRESP=00, RVALID 1 cycle after AR handshake.
- W sent 3 cycles before AW: write 0x12345678 to 0x08, then strobe write 0xAABBCCDD to 0x08 with WSTRB=4'b0101 -> reg2=0x12BB56DD.
- Write to addr 0x20 (index 8, NUM_REGS=8) -> BRESP=SLVERR, no wr_pulse, no register changes; read 0x20 -> RDATA=0, RRESP=10.
- RO_MASK=8'h80, hw_ro_in reg7=0xCAFEF00D: write 0x1 to 0x1C -> SLVERR, no pulse; read 0x1C -> 0xCAFEF00D, OKAY.
- Backpressure: BREADY and RREADY held low 5 cycles -> BVALID/RVALID/data/resp stable; second AW not accepted (AWREADY=0) until 1 cycle after the B handshake.
- Reset asserted in W_HAVE_ADDR and in R_DATA -> next cycle all VALIDs = 0, registers = 0, no BVALID ever issued for the abandoned write.

Source files
------------

// File: rtl/axi_4_lite_regbank_if.sv
// AXI4-Lite bus bundle between an interconnect master and the register bank.
// Latency: none, wires only.
// Backpressure: carries the five valid/ready channel handshakes unchanged.
interface axi_4_lite_regbank_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    // write address channel
    logic                      S_AXI_AWVALID;
    logic                      S_AXI_AWREADY;
    logic [ADDR_WIDTH-1:0]     S_AXI_AWADDR;
    logic [2:0]                S_AXI_AWPROT;
    // write data channel
    logic                      S_AXI_WVALID;
    logic                      S_AXI_WREADY;
    logic [DATA_WIDTH-1:0]     S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
    // write response channel
    logic                      S_AXI_BVALID;
    logic                      S_AXI_BREADY;
    logic [1:0]                S_AXI_BRESP;
    // read address channel
    logic                      S_AXI_ARVALID;
    logic                      S_AXI_ARREADY;
    logic [ADDR_WIDTH-1:0]     S_AXI_ARADDR;
    logic [2:0]                S_AXI_ARPROT;
    // read data channel
    logic                      S_AXI_RVALID;
    logic                      S_AXI_RREADY;
    logic [DATA_WIDTH-1:0]     S_AXI_RDATA;
    logic [1:0]                S_AXI_RRESP;

    modport master (
        output S_AXI_AWVALID, S_AXI_AWADDR, S_AXI_AWPROT,
        input  S_AXI_AWREADY,
        output S_AXI_WVALID, S_AXI_WDATA, S_AXI_WSTRB,
        input  S_AXI_WREADY,
        input  S_AXI_BVALID, S_AXI_BRESP,
        output S_AXI_BREADY,
        output S_AXI_ARVALID, S_AXI_ARADDR, S_AXI_ARPROT,
        input  S_AXI_ARREADY,
        input  S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWVALID, S_AXI_AWADDR, S_AXI_AWPROT,
        output S_AXI_AWREADY,
        input  S_AXI_WVALID, S_AXI_WDATA, S_AXI_WSTRB,
        output S_AXI_WREADY,
        output S_AXI_BVALID, S_AXI_BRESP,
        input  S_AXI_BREADY,
        input  S_AXI_ARVALID, S_AXI_ARADDR, S_AXI_ARPROT,
        output S_AXI_ARREADY,
        output S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP,
        input  S_AXI_RREADY
    );
endinterface

// File: rtl/axi_4_lite_regbank.sv
// Parametrised AXI4-Lite slave register bank with byte strobes, RO hardware registers and SLVERR decode.
// Latency: AW+W handshake to BVALID 2 cycles; AR handshake to RVALID 1 cycle.
// Backpressure: BVALID/RVALID held with stable payload until BREADY/RREADY; no new AW/W or AR accepted meanwhile.
// Ports: S_AXI_ACLK/S_AXI_ARESETN (sync active-low), s_axi (AXI4-Lite slave modport),
//        regs_out (flattened RW contents, RO slots zero), hw_ro_in (RO values), wr_pulse (per-register update strobe).
module axi_4_lite_regbank #(
    parameter int                 DATA_WIDTH = 32,
    parameter int                 ADDR_WIDTH = 8,
    parameter int                 NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK   = '0
) (
    input  logic                           S_AXI_ACLK,
    input  logic                           S_AXI_ARESETN,
    axi_4_lite_regbank_if.slave            s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_ro_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
    localparam int IDX_WIDTH  = ADDR_WIDTH - ADDR_LSB;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
        $error("axi_4_lite_regbank: DATA_WIDTH must be 32 or 64");
    end
    if (NUM_REGS < 2 || NUM_REGS > (1 << IDX_WIDTH)) begin : g_bad_regs
        $error("axi_4_lite_regbank: NUM_REGS out of range for ADDR_WIDTH");
    end

    // One-hot register select; all zero for an index beyond the bank.
    function automatic logic [NUM_REGS-1:0] decode(input logic [IDX_WIDTH-1:0] idx);
        logic [NUM_REGS-1:0] hit;
        hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == IDX_WIDTH'(i)) hit[i] = 1'b1;
        end
        return hit;
    endfunction

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_COMMIT, W_RESP
    } w_state_t;

    w_state_t               w_state_q, w_state_d;
    logic                   aw_rdy_q, aw_rdy_d;
    logic                   w_rdy_q, w_rdy_d;
    logic                   b_vld_q, b_vld_d;
    logic [1:0]             b_resp_q, b_resp_d;
    logic [IDX_WIDTH-1:0]   widx_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [STRB_WIDTH-1:0]  wstrb_q;
    logic                   aw_hs, w_hs;
    logic [NUM_REGS-1:0]    w_en;

    assign aw_hs = s_axi.S_AXI_AWVALID && aw_rdy_q;
    assign w_hs  = s_axi.S_AXI_WVALID  && w_rdy_q;
    // Only writable, in-range registers are enabled; an empty w_en during commit means SLVERR.
    assign w_en  = (w_state_q == W_COMMIT) ? (decode(widx_q) & ~RO_MASK) : '0;

    always_comb begin
        w_state_d = w_state_q;
        b_vld_d   = b_vld_q;
        b_resp_d  = b_resp_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs)  w_state_d = W_COMMIT;
                else if (aw_hs)     w_state_d = W_HAVE_ADDR;
                else if (w_hs)      w_state_d = W_HAVE_DATA;
            end
            W_HAVE_ADDR: if (w_hs)  w_state_d = W_COMMIT;
            W_HAVE_DATA: if (aw_hs) w_state_d = W_COMMIT;
            W_COMMIT: begin
                w_state_d = W_RESP;
                b_vld_d   = 1'b1;
                b_resp_d  = (|w_en) ? RESP_OKAY : RESP_SLVERR;
            end
            W_RESP: begin
                if (s_axi.S_AXI_BREADY) begin
                    w_state_d = W_IDLE;
                    b_vld_d   = 1'b0;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        // Readies are registered from the next state, so they stay low for the
        // first cycle after reset and reopen one cycle after the B handshake.
        aw_rdy_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_DATA);
        w_rdy_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_ADDR);
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            w_state_q <= W_IDLE;
            aw_rdy_q  <= 1'b0;
            w_rdy_q   <= 1'b0;
            b_vld_q   <= 1'b0;
            b_resp_q  <= RESP_OKAY;
            widx_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wr_pulse  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_rdy_q  <= aw_rdy_d;
            w_rdy_q   <= w_rdy_d;
            b_vld_q   <= b_vld_d;
            b_resp_q  <= b_resp_d;
            if (aw_hs) widx_q <= s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
            if (w_hs) begin
                wdata_q <= s_axi.S_AXI_WDATA;
                wstrb_q <= s_axi.S_AXI_WSTRB;
            end
            // Pulse fires even with an all-zero strobe: the access itself is the event.
            wr_pulse <= w_en;
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < STRB_WIDTH; b++) begin
                    if (w_en[i] && wstrb_q[b]) regs_q[i][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    r_state_t               r_state_q, r_state_d;
    logic                   ar_rdy_q, ar_rdy_d;
    logic                   r_vld_q, r_vld_d;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic [1:0]             rresp_q;
    logic                   ar_hs;
    logic [NUM_REGS-1:0]    r_hit;
    logic [DATA_WIDTH-1:0]  rd_word;

    assign ar_hs = s_axi.S_AXI_ARVALID && ar_rdy_q;
    assign r_hit = decode(s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB]);

    // Out-of-range reads leave rd_word at zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_hit[i]) rd_word = rd_word | (RO_MASK[i] ? hw_ro_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i]);
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = R_DATA;
            R_DATA:  if (s_axi.S_AXI_RREADY) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
        ar_rdy_d = (r_state_d == R_IDLE);
        r_vld_d  = (r_state_d == R_DATA);
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_state_q <= R_IDLE;
            ar_rdy_q  <= 1'b0;
            r_vld_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            ar_rdy_q  <= ar_rdy_d;
            r_vld_q   <= r_vld_d;
            if (ar_hs) begin
                rdata_q <= rd_word;
                rresp_q <= (|r_hit) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_axi.S_AXI_AWREADY = aw_rdy_q;
    assign s_axi.S_AXI_WREADY  = w_rdy_q;
    assign s_axi.S_AXI_BVALID  = b_vld_q;
    assign s_axi.S_AXI_BRESP   = b_resp_q;
    assign s_axi.S_AXI_ARREADY = ar_rdy_q;
    assign s_axi.S_AXI_RVALID  = r_vld_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[g] ? '0 : regs_q[g];
    end

    // Protection bits and sub-word address bits carry no meaning here.
    logic unused_sigs;
    assign unused_sigs = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                           s_axi.S_AXI_AWADDR[ADDR_LSB-1:0], s_axi.S_AXI_ARADDR[ADDR_LSB-1:0]};
endmodule
